if_stage_prefetch: RTL and testbench

Parametrised instruction-fetch stage for the mips_16 pipeline. It owns the fetch PC, issues requests to a 1-cycle-latency synchronous instruction memory, and buffers returned instructions with their PCs in a small prefetch FIFO. Decode pulls from the FIFO through a valid/ready handshake. Branch redirects from decode compute a sign-extended relative target, flush the FIFO and squash the in-flight fetch.

---
 rtl/if_stage_prefetch.sv | 117 +++++++++++
 tb/tb_if_stage_prefetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with prefetch FIFO for the mips_16 pipeline.
// Owns the fetch PC and issues requests to a 1-cycle synchronous
// instruction memory. Returned words are buffered with their PCs, and
// decode drains them through a valid/ready handshake.
// Optional feature: define IF_STAGE_ABS_JUMP_EN to add absolute redirect
// targets (ports redirect_abs / redirect_target).
module if_stage_prefetch #(
  parameter int unsigned          PC_WIDTH     = 8,
  parameter int unsigned          INSTR_WIDTH  = 16,
  parameter int unsigned          OFFSET_WIDTH = 6,
  parameter int unsigned          FIFO_DEPTH   = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_en,
  input  logic                    redirect_valid,
  input  logic [PC_WIDTH-1:0]     redirect_pc,
  input  logic [OFFSET_WIDTH-1:0] redirect_offset,
`ifdef IF_STAGE_ABS_JUMP_EN
  input  logic                    redirect_abs,
  input  logic [PC_WIDTH-1:0]     redirect_target,
`endif
  output logic                    imem_req,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0]  imem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSTR_WIDTH-1:0]  out_instr,
  output logic [PC_WIDTH-1:0]     out_pc
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    inflight_pc;
  logic                   inflight;
  logic [PC_WIDTH-1:0]    fifo_pc    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [PC_WIDTH-1:0]    offset_ext;
  logic [PC_WIDTH-1:0]    target;
  logic                   push;
  logic                   pop;

  // Signed size cast sign-extends the offset from its top bit.
  assign offset_ext = PC_WIDTH'($signed(redirect_offset));

  // Redirect target: relative by default, absolute when selected.
  always_comb begin
    target = redirect_pc + offset_ext;
`ifdef IF_STAGE_ABS_JUMP_EN
    if (redirect_abs) begin
      target = redirect_target;
    end
`endif
  end

  // A request is allowed only when the FIFO has room for every word that
  // could land in it. A same-cycle pop does not count as free space.
  assign imem_req  = ~rst & fetch_en & ~redirect_valid &
                     ((count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;

  assign push      = inflight & ~redirect_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_instr = fifo_instr[rd_ptr];
  assign out_pc    = fifo_pc[rd_ptr];

  // Fetch PC, in-flight tracking, and FIFO pointers/count. Redirect wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_WIDTH'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: captures the returning word together with its PC.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch. It covers streaming, stall/credit,
// relative redirect with flush, PC wrap, reset with a fetch in flight, and
// absolute redirects when IF_STAGE_ABS_JUMP_EN is defined.
module tb_if_stage_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic [5:0]  redirect_offset = '0;
`ifdef IF_STAGE_ABS_JUMP_EN
  logic        redirect_abs = 1'b0;
  logic [7:0]  redirect_target = '0;
`endif
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;

  int checks = 0;
  int errors = 0;

  if_stage_prefetch #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (16),
    .OFFSET_WIDTH(6),
    .FIFO_DEPTH  (4),
    .RESET_PC    (8'h00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_offset(redirect_offset),
`ifdef IF_STAGE_ABS_JUMP_EN
    .redirect_abs   (redirect_abs),
    .redirect_target(redirect_target),
`endif
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // Memory contents: upper byte is the address XOR 0x5A, lower byte is the address.
  function automatic logic [15:0] word(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  // Synchronous instruction memory with one cycle of latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= word(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Assert reset now, check the outputs while reset is held, and release it
  // at the start of a new cycle (posedge + 1).
  task automatic do_reset(input string tag);
    rst = 1'b1;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    #3;
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_req"},   imem_req,  0);
    check({tag, "_addr"},  imem_addr, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    // Streaming from reset
    do_reset("rst0");
    for (int c = 0; c < 8; c++) begin
      fetch_en = 1'b1; out_ready = 1'b1;
      #3;
      check("s_req",  imem_req,  1);
      check("s_addr", imem_addr, c);
      if (c >= 2) begin
        check("s_valid", out_valid, 1);
        check("s_pc",    out_pc,    c - 2);
        check("s_instr", out_instr, word(8'(c - 2)));
      end else begin
        check("s_valid0", out_valid, 0);
      end
      @(posedge clk); #1;
    end

    // Stall: fill the FIFO, then drain without gaps
    do_reset("rst1");
    for (int c = 0; c < 17; c++) begin
      fetch_en = 1'b1;
      out_ready = (c >= 10);
      #3;
      if (c <= 3) check("st_req_on", imem_req, 1);
      if (c >= 4 && c <= 10) check("st_req_off", imem_req, 0);
      if (c == 9) begin
        check("st_full_pc", out_pc, 8'h00);
        check("st_addr",    imem_addr, 8'h04);
      end
      if (c == 11) begin
        check("st_resume", imem_req, 1);
        check("st_raddr",  imem_addr, 8'h04);
      end
      if (c >= 10) begin
        check("st_valid", out_valid, 1);
        check("st_pc",    out_pc, c - 10);
      end
      @(posedge clk); #1;
    end

    // Relative redirect with negative offset while 3 entries are held
    do_reset("rst2");
    for (int c = 0; c < 9; c++) begin
      fetch_en = 1'b1;
      out_ready = (c >= 5);
      redirect_valid = (c == 4);
      redirect_pc = 8'h10;
      redirect_offset = 6'b111100;
      #3;
      if (c == 3) check("rd_pre_pc", out_pc, 8'h00);
      if (c == 4) check("rd_req",    imem_req, 0);
      if (c == 5) begin
        check("rd_v1",    out_valid, 0);
        check("rd_addr1", imem_addr, 8'h0C);
      end
      if (c == 6) begin
        check("rd_v2",    out_valid, 0);
        check("rd_addr2", imem_addr, 8'h0D);
      end
      if (c == 7) begin
        check("rd_v3",    out_valid, 1);
        check("rd_pc3",   out_pc, 8'h0C);
        check("rd_ins3",  out_instr, 16'h560C);
      end
      if (c == 8) check("rd_pc4", out_pc, 8'h0D);
      @(posedge clk); #1;
    end

    // PC wrap and redirect whose target wraps past 0xFF
    do_reset("rst3");
    for (int c = 0; c < 10; c++) begin
      fetch_en = 1'b1; out_ready = 1'b1;
      redirect_valid = (c == 0) || (c == 6);
      redirect_pc = (c == 0) ? 8'h00 : 8'hFF;
      redirect_offset = (c == 0) ? 6'b111110 : 6'b000011;
      #3;
      if (c == 0) check("w_req_pri", imem_req, 0);
      if (c == 1) check("w_addr_fe", imem_addr, 8'hFE);
      if (c == 2) check("w_addr_ff", imem_addr, 8'hFF);
      if (c == 3) check("w_pc_fe",   out_pc, 8'hFE);
      if (c == 4) check("w_pc_ff",   out_pc, 8'hFF);
      if (c == 5) begin
        check("w_pc_00",  out_pc, 8'h00);
        check("w_ins_00", out_instr, 16'h5A00);
      end
      if (c == 6) begin
        check("w_rreq", imem_req, 0);
        check("w_pc01", out_pc, 8'h01);
      end
      if (c == 7) begin
        check("w_v7",    out_valid, 0);
        check("w_tgt",   imem_addr, 8'h02);
      end
      if (c == 8) check("w_v8", out_valid, 0);
      if (c == 9) check("w_pc02", out_pc, 8'h02);
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;

    // Reset with a fetch in flight and two entries buffered
    do_reset("rst4");
    for (int c = 0; c < 4; c++) begin
      fetch_en = 1'b1; out_ready = 1'b0;
      #3;
      if (c == 3) begin
        check("ri_valid", out_valid, 1);
        check("ri_req",   imem_req, 1);
      end
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    do_reset("rst_mid");
    for (int c = 0; c < 4; c++) begin
      fetch_en = 1'b1; out_ready = 1'b1;
      #3;
      if (c == 1) check("ri_v1",  out_valid, 0);
      if (c == 2) check("ri_pc2", out_pc, 8'h00);
      if (c == 3) check("ri_pc3", out_pc, 8'h01);
      @(posedge clk); #1;
    end

`ifdef IF_STAGE_ABS_JUMP_EN
    // Absolute redirect, then a relative one with the target port ignored
    do_reset("rst5");
    for (int c = 0; c < 7; c++) begin
      fetch_en = 1'b1; out_ready = 1'b1;
      redirect_valid = (c == 0) || (c == 3);
      redirect_abs = (c == 0);
      redirect_target = 8'h40;
      redirect_pc = (c == 0) ? 8'h10 : 8'h20;
      redirect_offset = (c == 0) ? 6'd0 : 6'd5;
      #3;
      if (c == 1) check("ab_addr", imem_addr, 8'h40);
      if (c == 3) check("ab_pc",   out_pc, 8'h40);
      if (c == 4) check("rel_addr", imem_addr, 8'h25);
      if (c == 6) check("rel_pc",  out_pc, 8'h25);
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
